mole_scheduler: RTL

Round sequencer for the whack-a-mole game. Drives the 18-bit LFSR random source through its `change` strobe, turns each fresh random word into a set of lit moles, times how long the moles stay up, clears moles as they are hit, and keeps the hit and miss tallies. It sits between the random source, the debounced button bank and the LED driver.

---
 rtl/mole_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: requests random words, lights a mole set, times each round,
// scores hits, counts misses and sequences a fixed number of rounds per game.
module mole_scheduler #(
    parameter int unsigned          NUM_MOLES   = 18,
    parameter logic [NUM_MOLES-1:0] ENABLE_MASK = 18'h3FFFF,
    parameter int unsigned          ON_TICKS    = 500,
    parameter int unsigned          GAP_TICKS   = 250,
    parameter int unsigned          ROUNDS      = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_MOLES-1:0] hit,
    input  logic [17:0]          rng_value,
    output logic                 rng_change,
    output logic [NUM_MOLES-1:0] mole_mask,
    output logic [7:0]           score,
    output logic [7:0]           misses,
    output logic [7:0]           round_num,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StSample,
        StShow,
        StGap,
        StDone
    } state_e;

    localparam logic [15:0] OnLast    = 16'(ON_TICKS - 1);
    localparam logic [15:0] GapLast   = 16'(GAP_TICKS - 1);
    localparam logic [7:0]  LastRound = 8'(ROUNDS);

    function automatic logic [4:0] popcount(input logic [NUM_MOLES-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    state_e      state_q;
    logic [15:0] tick_cnt_q;
    logic [1:0]  retry_q;

    logic [NUM_MOLES-1:0] cand;
    logic [NUM_MOLES-1:0] hits;
    logic [NUM_MOLES-1:0] mask_after;
    logic [8:0]           score_sum;
    logic [8:0]           miss_sum;
    logic [7:0]           score_sat;
    logic [7:0]           miss_sat;
    logic [7:0]           round_next;
    logic                 timeout;
    logic                 round_end;
    logic                 gap_exit;

    always_comb begin
        cand       = NUM_MOLES'(rng_value) & ENABLE_MASK;
        hits       = hit & mole_mask;
        mask_after = mole_mask & ~hits;
        score_sum  = {1'b0, score} + {4'b0, popcount(hits)};
        // Misses are what is still lit after this cycle's hits have been taken off.
        miss_sum   = {1'b0, misses} + {4'b0, popcount(mask_after)};
        score_sat  = score_sum[8] ? 8'hFF : score_sum[7:0];
        miss_sat   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        timeout    = tick && (tick_cnt_q == OnLast);
        round_end  = timeout || (mask_after == '0);
        round_next = round_num + 8'd1;
        gap_exit   = (GAP_TICKS == 0) || (tick && (tick_cnt_q == GapLast));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            retry_q    <= '0;
            rng_change <= 1'b0;
            mole_mask  <= '0;
            score      <= '0;
            misses     <= '0;
            round_num  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort && (state_q != StIdle)) begin
            // Tallies survive an abort so the final result can still be shown.
            state_q    <= StIdle;
            rng_change <= 1'b0;
            mole_mask  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rng_change <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        score      <= '0;
                        misses     <= '0;
                        round_num  <= '0;
                        retry_q    <= '0;
                        tick_cnt_q <= '0;
                        rng_change <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    state_q <= StSample;
                end
                StSample: begin
                    if (cand != '0) begin
                        mole_mask  <= cand;
                        tick_cnt_q <= '0;
                        retry_q    <= '0;
                        state_q    <= StShow;
                    end else if (retry_q != 2'd3) begin
                        retry_q    <= retry_q + 2'd1;
                        rng_change <= 1'b1;
                        state_q    <= StReq;
                    end else begin
                        // Four empty words in a row: fall back to mole 0 so the round still runs.
                        mole_mask  <= NUM_MOLES'(1);
                        tick_cnt_q <= '0;
                        retry_q    <= '0;
                        state_q    <= StShow;
                    end
                end
                StShow: begin
                    score <= score_sat;
                    if (tick) begin
                        tick_cnt_q <= tick_cnt_q + 16'd1;
                    end
                    if (round_end) begin
                        mole_mask  <= '0;
                        round_num  <= round_next;
                        tick_cnt_q <= '0;
                        if (timeout) begin
                            misses <= miss_sat;
                        end
                        if (round_next == LastRound) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StGap;
                        end
                    end else begin
                        mole_mask <= mask_after;
                    end
                end
                StGap: begin
                    if (gap_exit) begin
                        rng_change <= 1'b1;
                        state_q    <= StReq;
                    end else if (tick) begin
                        tick_cnt_q <= tick_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
